rat_intr_ctrl: RTL and testbench



---
 rtl/rat_intr_ctrl_if.sv | 10 +
 rtl/rat_intr_ctrl.sv | 104 ++++++++++
 tb/tb_rat_intr_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rat_intr_ctrl_if.sv
// rtl/rat_intr_ctrl_if.sv - MCU I/O port bus between RAT_MCU and the interrupt controller
interface rat_intr_ctrl_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] DOUT;

  modport master (output PORT_ID, output OUT_PORT, output IO_STRB, input DOUT);
  modport slave  (input PORT_ID, input OUT_PORT, input IO_STRB, output DOUT);
endinterface

// File: rtl/rat_intr_ctrl.sv
// rtl/rat_intr_ctrl.sv - eight-source edge-latched interrupt controller for the RAT MCU
module rat_intr_ctrl #(
  parameter logic [7:0] BASE_ID = 8'h30,
  parameter int         N_SRC   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            IRQ,
  rat_intr_ctrl_if.slave        io,
  output logic                  INTR
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << N_SRC) - 9'd1);

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} state_t;

  state_t     state_q, state_d;
  logic [7:0] s1_q, s2_q, prev_q;
  logic [7:0] mask_q, mask_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] active_id_q, active_id_d;
  logic       intr_q, intr_d;

  logic       match, wr_en, wr_mask, wr_ack, wr_eoi;
  logic [7:0] rise, eligible, ack_clr;
  logic [2:0] win_id;

  always_comb begin
    match   = (io.PORT_ID[7:2] == BASE_ID[7:2]);
    wr_en   = io.IO_STRB & match;
    wr_mask = wr_en & (io.PORT_ID[1:0] == 2'd0);
    wr_ack  = wr_en & (io.PORT_ID[1:0] == 2'd2);
    wr_eoi  = wr_en & (io.PORT_ID[1:0] == 2'd3);
  end

  assign rise     = s2_q & ~prev_q;
  assign eligible = pending_q & mask_q;

  // Descending scan so the lowest eligible index is the last assignment.
  always_comb begin
    win_id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) win_id = 3'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      s1_q        <= 8'h00;
      s2_q        <= 8'h00;
      prev_q      <= 8'h00;
      mask_q      <= 8'h00;
      pending_q   <= 8'h00;
      active_id_q <= 3'd0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= IRQ & SRC_MASK;
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      active_id_q <= active_id_d;
      intr_q      <= intr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|eligible) state_d = ST_ASSERT;
      ST_ASSERT:  if (wr_ack)    state_d = ST_SERVICE;
      ST_SERVICE: if (wr_eoi)    state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // A new edge on the bit being acknowledged wins over the clear.
  always_comb begin
    ack_clr     = 8'h00;
    active_id_d = active_id_q;
    if (state_q == ST_ASSERT && wr_ack) ack_clr = 8'h01 << active_id_q;
    if (state_q == ST_IDLE && |eligible) active_id_d = win_id;
    pending_d = ((pending_q & ~ack_clr) | rise) & SRC_MASK;
    mask_d    = wr_mask ? (io.OUT_PORT & SRC_MASK) : mask_q;
    intr_d    = (state_d == ST_ASSERT);
  end

  always_comb begin
    io.DOUT = 8'h00;
    if (match) begin
      case (io.PORT_ID[1:0])
        2'd0:    io.DOUT = mask_q;
        2'd1:    io.DOUT = pending_q;
        2'd2:    io.DOUT = {(state_q != ST_IDLE), 4'b0000, active_id_q};
        default: io.DOUT = 8'h00;
      endcase
    end
  end

  assign INTR = intr_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// tb/tb_rat_intr_ctrl.sv - directed self-checking bench for rat_intr_ctrl
module tb_rat_intr_ctrl;
  localparam logic [7:0] A_MASK = 8'h30;
  localparam logic [7:0] A_PEND = 8'h31;
  localparam logic [7:0] A_ID   = 8'h32;
  localparam logic [7:0] A_EOI  = 8'h33;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] IRQ;
  logic       INTR;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] rv;

  rat_intr_ctrl_if io();

  rat_intr_ctrl #(.BASE_ID(8'h30), .N_SRC(8)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .IRQ  (IRQ),
    .io   (io.slave),
    .INTR (INTR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    io.PORT_ID  = a;
    io.OUT_PORT = d;
    io.IO_STRB  = 1'b1;
    tick(1);
    io.IO_STRB  = 1'b0;
    io.PORT_ID  = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    io.PORT_ID = a;
    #1;
    d = io.DOUT;
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  initial begin
    RST = 1'b1;
    IRQ = 8'h00;
    io.PORT_ID = 8'h00;
    io.OUT_PORT = 8'h00;
    io.IO_STRB = 1'b0;
    tick(3);
    RST = 1'b0;
    tick(1);

    // reset state
    chk_reg("rst_mask", A_MASK, 8'h00);
    chk_reg("rst_pend", A_PEND, 8'h00);
    chk_reg("rst_id",   A_ID,   8'h00);
    check("rst_intr", {7'b0, INTR}, 8'h00);
    chk_reg("nomatch", 8'h34, 8'h00);

    // single source 2
    wr(A_MASK, 8'h04);
    IRQ[2] = 1'b1;
    tick(2);
    chk_reg("s2_pend_early", A_PEND, 8'h00);
    tick(1);
    chk_reg("s2_pend", A_PEND, 8'h04);
    check("s2_intr_early", {7'b0, INTR}, 8'h00);
    tick(1);
    check("s2_intr", {7'b0, INTR}, 8'h01);
    chk_reg("s2_id", A_ID, 8'h82);
    wr(A_PEND, 8'hFF);
    chk_reg("pend_ro", A_PEND, 8'h04);
    wr(A_ID, 8'h00);
    check("s2_ack_intr", {7'b0, INTR}, 8'h00);
    chk_reg("s2_ack_pend", A_PEND, 8'h00);
    chk_reg("s2_svc_id", A_ID, 8'h82);
    chk_reg("eoi_read", A_EOI, 8'h00);
    wr(A_EOI, 8'h00);
    chk_reg("s2_idle_id", A_ID, 8'h02);
    IRQ[2] = 1'b0;
    wr(A_ID, 8'h00);
    chk_reg("ack_idle_id", A_ID, 8'h02);

    // two sources, priority
    wr(A_MASK, 8'hFF);
    IRQ[5] = 1'b1;
    IRQ[1] = 1'b1;
    tick(4);
    check("pr_intr1", {7'b0, INTR}, 8'h01);
    chk_reg("pr_id1", A_ID, 8'h81);
    chk_reg("pr_pend1", A_PEND, 8'h22);
    wr(A_ID, 8'h00);
    chk_reg("pr_pend2", A_PEND, 8'h20);
    wr(A_EOI, 8'h00);
    check("pr_intr_eoi", {7'b0, INTR}, 8'h00);
    tick(1);
    check("pr_intr2", {7'b0, INTR}, 8'h01);
    chk_reg("pr_id2", A_ID, 8'h85);
    wr(A_ID, 8'h00);
    wr(A_EOI, 8'h00);
    IRQ = 8'h00;
    tick(3);

    // masked source, later unmasked
    wr(A_MASK, 8'h00);
    IRQ[3] = 1'b1;
    tick(4);
    chk_reg("mk_pend", A_PEND, 8'h08);
    check("mk_intr0", {7'b0, INTR}, 8'h00);
    wr(A_MASK, 8'h08);
    check("mk_intr_w", {7'b0, INTR}, 8'h00);
    tick(1);
    check("mk_intr1", {7'b0, INTR}, 8'h01);
    chk_reg("mk_id", A_ID, 8'h83);
    wr(A_ID, 8'h00);
    wr(A_EOI, 8'h00);
    IRQ[3] = 1'b0;
    tick(3);

    // new edge coincides with ACK of the same source
    wr(A_MASK, 8'h01);
    IRQ[0] = 1'b1;
    tick(4);
    check("co_intr", {7'b0, INTR}, 8'h01);
    chk_reg("co_id", A_ID, 8'h80);
    IRQ[0] = 1'b0;
    tick(3);
    IRQ[0] = 1'b1;
    tick(2);
    wr(A_ID, 8'h00);
    chk_reg("co_pend", A_PEND, 8'h01);
    check("co_intr_ack", {7'b0, INTR}, 8'h00);
    wr(A_EOI, 8'h00);
    tick(1);
    check("co_intr_re", {7'b0, INTR}, 8'h01);
    wr(A_ID, 8'h00);
    wr(A_EOI, 8'h00);
    IRQ = 8'h00;
    tick(3);

    // reset in SERVICE with pending 0x30
    wr(A_MASK, 8'h01);
    IRQ[0] = 1'b1;
    tick(4);
    wr(A_ID, 8'h00);
    IRQ[5:4] = 2'b11;
    tick(3);
    chk_reg("rs_pend_pre", A_PEND, 8'h30);
    chk_reg("rs_id_pre", A_ID, 8'h80);
    IRQ = 8'h00;
    tick(3);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk_reg("rs_mask", A_MASK, 8'h00);
    chk_reg("rs_pend", A_PEND, 8'h00);
    chk_reg("rs_id", A_ID, 8'h00);
    check("rs_intr", {7'b0, INTR}, 8'h00);
    wr(A_EOI, 8'h00);
    tick(2);
    chk_reg("rs_eoi_id", A_ID, 8'h00);
    check("rs_eoi_intr", {7'b0, INTR}, 8'h00);

    rv = 8'h00;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
